// File: rtl/io_bus_arbiter.sv
// Two-master IO bus arbiter: alternating priority with bounded lock ownership.
// A grant issues one single-cycle transfer; read data is returned the cycle after.
module io_bus_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [31:0] m1_wr_data,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rd_valid,
  output logic        m1_rd_valid,
  output logic [31:0] m0_rd_data,
  output logic [31:0] m1_rd_data,
  output logic        bus_cs,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data
);

  localparam int unsigned CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e           state_q;
  logic             last_q;
  logic             sel_q;
  logic [CNT_W-1:0] lock_cnt_q;

  logic             sel_d;
  logic [CNT_W-1:0] lock_cnt_d;
  logic             last_req, last_lock, other_req, lock_ok;
  logic             wr_d;
  logic [31:0]      addr_d, wdata_d;

  // Arbitration decision, only consumed in IDLE
  always_comb begin
    last_req  = last_q ? m1_req  : m0_req;
    last_lock = last_q ? m1_lock : m0_lock;
    other_req = last_q ? m0_req  : m1_req;
    lock_ok   = last_lock && last_req && (lock_cnt_q < CNT_W'(LOCK_MAX));

    if (m0_req && m1_req) sel_d = lock_ok ? last_q : ~last_q;
    else                  sel_d = m1_req;

    lock_cnt_d = lock_cnt_q;
    if ((sel_d != last_q) || !last_lock) lock_cnt_d = '0;
    else if (other_req)                  lock_cnt_d = lock_cnt_q + CNT_W'(1);

    wr_d    = sel_d ? m1_wr      : m0_wr;
    addr_d  = sel_d ? m1_addr    : m0_addr;
    wdata_d = sel_d ? m1_wr_data : m0_wr_data;
  end

  // State, command register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      lock_cnt_q  <= '0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
      bus_cs      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      bus_cs      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q     <= ISSUE;
            sel_q       <= sel_d;
            last_q      <= sel_d;
            lock_cnt_q  <= lock_cnt_d;
            bus_cs      <= 1'b1;
            bus_wr      <= wr_d;
            bus_rd      <= ~wr_d;
            bus_addr    <= addr_d;
            bus_wr_data <= wdata_d;
            m0_gnt      <= ~sel_d;
            m1_gnt      <= sel_d;
          end
        end
        ISSUE: begin
          // Requests still high here belong to the transfer just issued
          state_q <= IDLE;
          if (bus_rd) begin
            if (sel_q) begin
              m1_rd_data  <= bus_rd_data;
              m1_rd_valid <= 1'b1;
            end else begin
              m0_rd_data  <= bus_rd_data;
              m0_rd_valid <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 4, maximum consecutive grants to one locked master while the other master requests.
REQ-002 Port: clk  in  1  system clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: m0_req / m1_req  in  1  master N requests one IO transfer; held high until mN_gnt.
REQ-005 Port: m0_wr / m1_wr  in  1  1 = write, 0 = read; stable while mN_req is high.
REQ-006 Port: m0_lock / m1_lock  in  1  master N requests back-to-back ownership.
REQ-007 Port: m0_addr / m1_addr  in  32  transfer address; stable while mN_req is high.
REQ-008 Port: m0_wr_data / m1_wr_data  in  32  write data; stable while mN_req is high.
REQ-009 Port: m0_gnt / m1_gnt  out  1  one-cycle pulse, transfer issued on the IO bus this cycle.
REQ-010 Port: m0_rd_valid / m1_rd_valid  out  1  one-cycle pulse, mN_rd_data is valid.
REQ-011 Port: m0_rd_data / m1_rd_data  out  32  captured read data.
REQ-012 Port: bus_cs, bus_wr, bus_rd  out  1 each  IO-bus strobes toward io_controller.
REQ-013 Port: bus_addr, bus_wr_data  out  32 each  IO-bus address and write data.
REQ-014 Port: bus_rd_data  in  32  IO-bus read data, valid combinationally in the cycle bus_rd is high.

Function
REQ-015 FSM states SHALL be IDLE and ISSUE; reset state is IDLE.
REQ-016 IDLE, no req: remain IDLE; all bus strobes 0.
REQ-017 IDLE, any req: register the selected master's wr/addr/wr_data, set sel, and enter ISSUE next edge.
REQ-018 ISSUE lasts exactly one cycle: bus_cs=1, bus_wr=wr, bus_rd=~wr, bus_addr/bus_wr_data from the registered command, m[sel]_gnt=1; next state is IDLE.
REQ-019 Arbitration uses a single pointer `last`: with both req high and no active lock, grant the master not equal to `last`; `last` is updated to sel on every grant.
REQ-020 Lock: if m[last]_lock and m[last]_req are high in IDLE and lock_cnt < LOCK_MAX, grant m[last] regardless of the other master's req.
REQ-021 lock_cnt increments on each lock-based grant while the other master requests; it clears when a grant goes to a different master or when m[last]_lock is 0 at arbitration.
REQ-022 When lock_cnt == LOCK_MAX and the other master requests, the grant goes to the other master (forced yield).
REQ-023 A lone requester is always granted, regardless of lock state or counter value.
REQ-024 Reads: bus_rd_data is captured into m[sel]_rd_data at the end of ISSUE; m[sel]_rd_valid pulses in the following cycle; the other master's rd_data is unchanged.
REQ-025 mN_rd_data holds its value until that master's next read completes.
REQ-026 Writes produce no rd_valid.
REQ-027 Latency: req seen in IDLE at cycle T -> gnt/bus strobe at T+1 -> rd_valid at T+2; peak throughput is one transfer per 2 cycles.
REQ-028 The gnt cycle overlaps the next IDLE arbitration; a master drops req on the edge after gnt, so the arbiter SHALL ignore a req that is still high in the same cycle it sees the gnt it issued.
REQ-029 Outputs bus_cs, bus_wr, bus_rd and all gnt / rd_valid are registered or decoded from state only; there is no combinational path from mN_req.

Reset
REQ-030 On reset assertion, immediately (asynchronously): state=IDLE, last=1 (m0 wins the first conflict), lock_cnt=0, all strobes/gnt/rd_valid=0, bus_addr/bus_wr_data/rd_data=0.
REQ-031 Reset during ISSUE aborts the transfer; no rd_valid is produced for it after reset release.
REQ-032 First arbitration occurs on the first rising edge after reset deasserts.

Verification
REQ-033 m0 read, addr 0x0000_0104, bus_rd_data=0xDEAD_BEEF -> bus_rd=1 at T+1, m0_gnt at T+1, m0_rd_valid with 0xDEAD_BEEF at T+2; m1 outputs idle.
REQ-034 Both masters request continuously, no lock -> grant order m0, m1, m0, m1, spaced 2 cycles apart.
REQ-035 m1 req+lock held, m0 req held, LOCK_MAX=4 -> m1 granted 4 times, then m0 once, then m1 resumes.
REQ-036 m0 write (0x10, 0x55) then m1 read -> bus_wr=1 with data 0x55, no m0_rd_valid; m1_rd_valid follows m1's grant.
REQ-037 Reset asserted in ISSUE of a read -> strobes drop the same cycle, no rd_valid afterwards, next conflict goes to m0.
REQ-038 Lone m1 with lock and lock_cnt saturated -> m1 still granted every 2 cycles.
